feature_map_pingpong_buffer: RTL and testbench

FEATURE_MAP_PINGPONG_BUFFER -- requirements
Module: feature_map_pingpong_buffer

---
 rtl/fmb_pkg.sv | 19 +
 rtl/fmb_dp_ram.sv | 25 ++
 rtl/feature_map_pingpong_buffer.sv | 170 +++++++++++++++++
 tb/tb_feature_map_pingpong_buffer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmb_pkg.sv
// Shared types and default sizes for the feature-map ping-pong buffer.
package fmb_pkg;

  localparam int DEF_DATA_WIDTH   = 144;
  localparam int DEF_ADDR_WIDTH   = 13;
  localparam int DEF_REPLAY_WIDTH = 4;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_READING = 2'd3
  } bank_state_e;

  function automatic logic bank_writable(input bank_state_e state);
    return (state == BANK_EMPTY) || (state == BANK_FILLING);
  endfunction

endpackage

// File: rtl/fmb_dp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// The read register only updates on rd_en, so it also serves as a holding stage.
module fmb_dp_ram #(
  parameter int DATA_WIDTH = 144,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: storage and its read register have no reset; a reset branch would
  // turn the array into flops instead of a RAM macro, and contents are don't-care.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/feature_map_pingpong_buffer.sv
// Two-bank ping-pong buffer between a conv-output write stream and a
// conv-input read stream with per-layer read replay. Optional: FMB_ERR_STATUS_EN.
module feature_map_pingpong_buffer
  import fmb_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int REPLAY_WIDTH = DEF_REPLAY_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [ADDR_WIDTH:0]     cfg_len,
  input  logic [REPLAY_WIDTH-1:0] cfg_replay,
  input  logic                    layer_start,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    wr_bank,
  output logic                    rd_bank,
  output logic                    layer_done,
  output logic                    busy
`ifdef FMB_ERR_STATUS_EN
  ,
  output logic                    err_sticky
`endif
);

  bank_state_e             bank_state [2];
  logic                    armed;
  logic [ADDR_WIDTH:0]     len_m1;
  logic [REPLAY_WIDTH-1:0] replay_last;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   rd_ptr;
  logic [REPLAY_WIDTH-1:0] pass_cnt;
  logic                    issued_all;
  logic                    rd_last;

  logic both_empty;
  logic cfg_ok;
  logic cfg_accept;
  logic wr_fire;
  logic wr_last;
  logic rd_fire;
  logic rd_issue;
  logic rd_wrap;
  logic last_pass;

  assign both_empty = (bank_state[0] == BANK_EMPTY) && (bank_state[1] == BANK_EMPTY);

`ifdef FMB_ERR_STATUS_EN
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  assign cfg_ok = (cfg_len != '0) && (cfg_len <= DEPTH);
`else
  assign cfg_ok = 1'b1;
`endif

  assign cfg_accept = layer_start && both_empty && cfg_ok;

  assign wr_ready  = armed && bank_writable(bank_state[wr_bank]);
  assign wr_fire   = wr_valid && wr_ready;
  assign wr_last   = ({1'b0, wr_ptr} == len_m1);

  // A new read is issued only if the output stage is free or drained this cycle.
  assign rd_fire   = rd_valid && rd_ready;
  assign rd_issue  = (bank_state[rd_bank] == BANK_READING) && !issued_all &&
                     (!rd_valid || rd_fire);
  assign rd_wrap   = ({1'b0, rd_ptr} == len_m1);
  assign last_pass = (pass_cnt == replay_last);

  assign busy = (bank_state[0] != BANK_EMPTY) || (bank_state[1] != BANK_EMPTY) || rd_valid;

  // NOTE: all state below uses non-blocking assignments so every branch sees
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bank_state[0] <= BANK_EMPTY;
      bank_state[1] <= BANK_EMPTY;
      armed         <= 1'b0;
      len_m1        <= '0;
      replay_last   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      pass_cnt      <= '0;
      issued_all    <= 1'b0;
      rd_last       <= 1'b0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      rd_valid      <= 1'b0;
      layer_done    <= 1'b0;
    end else begin
      layer_done <= 1'b0;

      if (cfg_accept) begin
        armed       <= 1'b1;
        len_m1      <= cfg_len - 1'b1;
        replay_last <= (cfg_replay == '0) ? '0 : cfg_replay - 1'b1;
      end

      // Write side only touches EMPTY/FILLING banks, read side only FULL/READING
      // ones, so both updates can land in the same cycle without conflict.
      if (wr_fire) begin
        if (wr_last) begin
          bank_state[wr_bank] <= BANK_FULL;
          wr_bank             <= ~wr_bank;
          wr_ptr              <= '0;
        end else begin
          bank_state[wr_bank] <= BANK_FILLING;
          wr_ptr              <= wr_ptr + 1'b1;
        end
      end

      if (bank_state[rd_bank] == BANK_FULL) bank_state[rd_bank] <= BANK_READING;

      if (rd_issue) begin
        rd_valid <= 1'b1;
        if (rd_wrap) begin
          rd_ptr <= '0;
          if (last_pass) begin
            pass_cnt   <= '0;
            issued_all <= 1'b1;
            rd_last    <= 1'b1;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
      end

      // layer_done rises together with the bank release, one cycle after the
      // final word is taken.
      if (rd_fire && rd_last) begin
        bank_state[rd_bank] <= BANK_EMPTY;
        rd_bank             <= ~rd_bank;
        issued_all          <= 1'b0;
        rd_last             <= 1'b0;
        layer_done          <= 1'b1;
      end
    end
  end

`ifdef FMB_ERR_STATUS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err_sticky <= 1'b0;
    end else if ((layer_start && !cfg_accept) || (wr_valid && !armed)) begin
      err_sticky <= 1'b1;
    end
  end
`endif

  fmb_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH + 1)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_fire),
    .wr_addr({wr_bank, wr_ptr}),
    .wr_data(wr_data),
    .rd_en  (rd_issue),
    .rd_addr({rd_bank, rd_ptr}),
    .rd_data(rd_data)
  );

endmodule

// File: tb/tb_feature_map_pingpong_buffer.sv
// Directed self-checking bench for feature_map_pingpong_buffer (small geometry).
// Define FMB_ERR_STATUS_EN to also exercise err_sticky.
module tb_feature_map_pingpong_buffer;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int RW = 4;

  logic          clk;
  logic          rstn;
  logic [AW:0]   cfg_len;
  logic [RW-1:0] cfg_replay;
  logic          layer_start;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          wr_bank;
  logic          rd_bank;
  logic          layer_done;
  logic          busy;
`ifdef FMB_ERR_STATUS_EN
  logic          err_sticky;
`endif

  feature_map_pingpong_buffer #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .REPLAY_WIDTH(RW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cfg_len    (cfg_len),
    .cfg_replay (cfg_replay),
    .layer_start(layer_start),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .wr_bank    (wr_bank),
    .rd_bank    (rd_bank),
    .layer_done (layer_done),
    .busy       (busy)
`ifdef FMB_ERR_STATUS_EN
    ,
    .err_sticky (err_sticky)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // rd_ready pattern: 0 = low, 1 = high, 2 = random
  int rd_mode = 0;
  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rd_mode)
        0:       rd_ready = 1'b0;
        1:       rd_ready = 1'b1;
        default: rd_ready = ($urandom_range(0, 1) != 0);
      endcase
    end
  end

  // Read-port monitor: collects accepted words, counts layer_done, checks hold.
  logic [DW-1:0] got_q[$];
  int            ld_cnt = 0;
  logic          hold_pending = 1'b0;
  logic [DW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (rstn) begin
      if (hold_pending) begin
        check("hold_valid", 32'(rd_valid), 32'd1);
        check("hold_data", 32'(rd_data), 32'(hold_data));
      end
      if (rd_valid && rd_ready) got_q.push_back(rd_data);
      if (layer_done) ld_cnt++;
    end
    hold_pending = rstn && rd_valid && !rd_ready;
    hold_data    = rd_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input int len, input int rep);
    cfg_len     = (AW+1)'(len);
    cfg_replay  = RW'(rep);
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  // Leaves wr_valid high so consecutive calls stream back to back.
  task automatic write_word(input logic [DW-1:0] d);
    int budget = 200;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!wr_ready && budget > 0) begin
      tick();
      budget--;
    end
    if (!wr_ready) check("wr_timeout", 32'(wr_ready), 32'd1);
    else tick();
  endtask

  task automatic wait_got(input int n);
    int budget = 1000;
    while (got_q.size() < n && budget > 0) begin
      tick();
      budget--;
    end
    if (got_q.size() < n) check("drain_timeout", got_q.size(), n);
  endtask

  int base;
  int ld0;
  logic [DW-1:0] exp1 [4] = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
  logic [DW-1:0] exp2 [6] = '{16'h0011, 16'h0022, 16'h0033, 16'h0011, 16'h0022, 16'h0033};

  initial begin
    rstn = 1'b0; layer_start = 1'b0; cfg_len = '0; cfg_replay = '0;
    wr_valid = 1'b0; wr_data = '0;
    tick(); tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_layer_done", 32'(layer_done), 32'd0);
    check("rst_wr_bank", 32'(wr_bank), 32'd0);
    check("rst_rd_bank", 32'(rd_bank), 32'd0);
`ifdef FMB_ERR_STATUS_EN
    check("rst_err", 32'(err_sticky), 32'd0);
`endif
    rstn = 1'b1;
    tick(); tick();
    check("idle_wr_ready", 32'(wr_ready), 32'd0);
    check("idle_rd_valid", 32'(rd_valid), 32'd0);

    // len=4, replay=1, A..D, with two-cycle first-word latency
    rd_mode = 1;
    start_layer(4, 1);
    check("t1_wr_ready", 32'(wr_ready), 32'd1);
    base = got_q.size(); ld0 = ld_cnt;
    write_word(16'h000A); write_word(16'h000B); write_word(16'h000C); write_word(16'h000D);
    wr_valid = 1'b0;
    check("t1_lat0", 32'(rd_valid), 32'd0);
    tick();
    check("t1_lat1", 32'(rd_valid), 32'd0);
    tick();
    check("t1_lat2_valid", 32'(rd_valid), 32'd1);
    check("t1_lat2_data", 32'(rd_data), 32'h000A);
    wait_got(base + 4);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) check($sformatf("t1_w%0d", i), 32'(got_q[base+i]), 32'(exp1[i]));
    check("t1_done", ld_cnt - ld0, 1);
    check("t1_rd_bank", 32'(rd_bank), 32'd1);
    check("t1_wr_bank", 32'(wr_bank), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // len=3, replay=2
    start_layer(3, 2);
    base = got_q.size(); ld0 = ld_cnt;
    write_word(16'h0011); write_word(16'h0022); write_word(16'h0033);
    wr_valid = 1'b0;
    wait_got(base + 6);
    repeat (4) tick();
    for (int i = 0; i < 6; i++) check($sformatf("t2_w%0d", i), 32'(got_q[base+i]), 32'(exp2[i]));
    check("t2_done", ld_cnt - ld0, 1);
    check("t2_rd_bank", 32'(rd_bank), 32'd0);

    // len=1, replay=0 (treated as 1): every write fills a bank
    start_layer(1, 0);
    base = got_q.size(); ld0 = ld_cnt;
    write_word(16'h0071); write_word(16'h0072); write_word(16'h0073);
    wr_valid = 1'b0;
    wait_got(base + 3);
    repeat (4) tick();
    for (int i = 0; i < 3; i++) check($sformatf("t3_w%0d", i), 32'(got_q[base+i]), 32'h71 + i);
    check("t3_done", ld_cnt - ld0, 3);

    // three layers of 8 with the reader stalled, then drain
    rd_mode = 0;
    start_layer(8, 1);
    base = got_q.size(); ld0 = ld_cnt;
    for (int i = 0; i < 16; i++) write_word(16'(16'h0040 + i));
    check("t4_full_wr_ready", 32'(wr_ready), 32'd0);
`ifdef FMB_ERR_STATUS_EN
    check("t4_err_before", 32'(err_sticky), 32'd0);
    start_layer(5, 3);
    check("t4_err_busy_start", 32'(err_sticky), 32'd1);
`endif
    repeat (4) tick();
    check("t4_still_blocked", 32'(wr_ready), 32'd0);
    check("t4_head_valid", 32'(rd_valid), 32'd1);
    check("t4_head_data", 32'(rd_data), 32'h0040);
    rd_mode = 1;
    for (int i = 16; i < 24; i++) write_word(16'(16'h0040 + i));
    wr_valid = 1'b0;
    wait_got(base + 24);
    repeat (4) tick();
    for (int i = 0; i < 24; i++) check($sformatf("t4_w%0d", i), 32'(got_q[base+i]), 32'h40 + i);
    check("t4_done", ld_cnt - ld0, 3);

    // full-depth layer with random rd_ready
    rd_mode = 2;
    start_layer(16, 1);
    base = got_q.size(); ld0 = ld_cnt;
    for (int i = 0; i < 16; i++) write_word(16'(16'h0080 + i));
    wr_valid = 1'b0;
    wait_got(base + 16);
    rd_mode = 1;
    repeat (4) tick();
    for (int i = 0; i < 16; i++) check($sformatf("t5_w%0d", i), 32'(got_q[base+i]), 32'h80 + i);
    check("t5_done", ld_cnt - ld0, 1);

    // reset in the middle of a read, then a fresh layer from bank 0
    rd_mode = 0;
    start_layer(4, 1);
    for (int i = 0; i < 4; i++) write_word(16'(16'h0091 + i));
    wr_valid = 1'b0;
    repeat (3) tick();
    check("t6_mid_valid", 32'(rd_valid), 32'd1);
    rstn = 1'b0;
    tick();
    check("t6_rst_rd_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_wr_ready", 32'(wr_ready), 32'd0);
    check("t6_rst_rd_bank", 32'(rd_bank), 32'd0);
    rstn = 1'b1;
    tick();
    rd_mode = 1;
    base = got_q.size();
    start_layer(2, 1);
    write_word(16'h0005); write_word(16'h0006);
    wr_valid = 1'b0;
    wait_got(base + 2);
    repeat (3) tick();
    check("t6_w0", 32'(got_q[base]), 32'h0005);
    check("t6_w1", 32'(got_q[base+1]), 32'h0006);
    check("t6_rd_bank", 32'(rd_bank), 32'd1);

`ifdef FMB_ERR_STATUS_EN
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    check("t7_err_cleared", 32'(err_sticky), 32'd0);
    start_layer(0, 1);
    check("t7_err_len0", 32'(err_sticky), 32'd1);
    check("t7_rejected", 32'(wr_ready), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
